// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared opcodes, FSM states and datapath select encodings for the multicycle RV32I controller
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so it is decoded outside the FSM.
    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        return op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the FSM's aluop plus instruction fields onto the ALU operation code
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    // Subtract only for R-type funct3=000 with funct7b5 set; addi never subtracts.
    always_comb
        alucontrol = aluop == ALUOP_SUB   ? ALU_SUB :
                     aluop != ALUOP_FUNCT ? ALU_ADD :
                     funct3 == 3'b000     ? (op5 & funct7b5 ? ALU_SUB : ALU_ADD) :
                     funct3 == 3'b010     ? ALU_SLT :
                     funct3 == 3'b110     ? ALU_OR  :
                     funct3 == 3'b111     ? ALU_AND : ALU_ADD;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: state-walk control FSM for the multicycle RV32I core with memory handshake and trap
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE  = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic [2:0] alucontrol,
    output logic       fault
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t         state, next;
    aluop_t         aluop;
    logic [CW-1:0]  wait_cnt;
    logic           is_mem, accept, timeout;
    logic           req, wr, irw, pcupdate, branch, rw, flt;

    assign is_mem  = state == FETCH || state == MEMREAD || state == MEMWRITE;
    assign accept  = (MEM_HANDSHAKE == 0) | mem_ready;
    assign timeout = is_mem & ~accept & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // State register; async reset may land in any state, including mid-write.
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= FETCH;
        else       state <= next;

    // Wait counter: runs only across consecutive non-accepted memory cycles.
    always_ff @(posedge clk or posedge reset)
        if (reset) wait_cnt <= '0;
        else       wait_cnt <= is_mem && !accept ? wait_cnt + 1'b1 : '0;

    // Next-state logic; an expired memory wait overrides every other transition.
    always_comb begin
        next = state;
        if (timeout) next = TRAP;
        else case (state)
            FETCH:    if (accept) next = DECODE;
            DECODE:   next = op == OP_LW || op == OP_SW ? MEMADR :
                             op == OP_R   ? EXECUTER :
                             op == OP_I   ? EXECUTEI :
                             op == OP_BEQ ? BEQ :
                             op == OP_JAL ? JAL : TRAP;
            MEMADR:   next = op == OP_LW ? MEMREAD : MEMWRITE;
            MEMREAD:  if (accept) next = MEMWB;
            MEMWRITE: if (accept) next = FETCH;
            EXECUTER, EXECUTEI, JAL: next = ALUWB;
            MEMWB, ALUWB, BEQ:       next = FETCH;
            default:  next = TRAP;
        endcase
    end

    // Moore outputs per state; FETCH commits IR/PC only in its accepted cycle.
    always_comb begin
        req       = 1'b0;
        wr        = 1'b0;
        adrsrc    = 1'b0;
        irw       = 1'b0;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        rw        = 1'b0;
        flt       = 1'b0;
        resultsrc = RES_ALUOUT;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        aluop     = ALUOP_ADD;
        case (state)
            FETCH:    begin req = 1'b1; alusrcb = SRCB_FOUR; resultsrc = RES_ALU; irw = accept; pcupdate = accept; end
            DECODE:   begin alusrca = SRCA_OLDPC; alusrcb = SRCB_IMM; end
            MEMADR:   begin alusrca = SRCA_RS1; alusrcb = SRCB_IMM; end
            MEMREAD:  begin req = 1'b1; adrsrc = 1'b1; end
            MEMWB:    begin resultsrc = RES_DATA; rw = 1'b1; end
            MEMWRITE: begin req = 1'b1; wr = 1'b1; adrsrc = 1'b1; end
            EXECUTER: begin alusrca = SRCA_RS1; alusrcb = SRCB_RS2; aluop = ALUOP_FUNCT; end
            EXECUTEI: begin alusrca = SRCA_RS1; alusrcb = SRCB_IMM; aluop = ALUOP_FUNCT; end
            ALUWB:    rw = 1'b1;
            BEQ:      begin alusrca = SRCA_RS1; alusrcb = SRCB_RS2; aluop = ALUOP_SUB; branch = 1'b1; end
            JAL:      begin alusrca = SRCA_OLDPC; alusrcb = SRCB_FOUR; pcupdate = 1'b1; end
            TRAP:     flt = 1'b1;
            default:  ;
        endcase
    end

    // Side-effecting strobes are held off for as long as reset is asserted.
    assign mem_req  = req & ~reset;
    assign memwrite = wr & ~reset;
    assign irwrite  = irw & ~reset;
    assign pcwrite  = (pcupdate | (branch & zero)) & ~reset;
    assign regwrite = rw & ~reset;
    assign fault    = flt & ~reset;
    assign immsrc   = imm_sel(op);

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (alucontrol)
    );

endmodule
